// File: rtl/mc_gen2_if.sv
// Pad-level loader/run controls and port bundle of the mc_gen2 accumulator core.
interface mc_gen2_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 6,
  parameter int unsigned NPORTS = 2
);
  logic                 loader_en;
  logic                 load;
  logic                 run;
  logic                 preload_en;
  logic [DW-1:0]        load_in;
  logic [NPORTS*DW-1:0] port_in;
  logic [NPORTS*DW-1:0] port_out;
  logic [AW-1:0]        preload_addr;
  logic                 preload_act_n;
  logic [4:0]           op_out;
  logic                 carry_out;
  logic                 halted;

  modport master (
    output loader_en, load, run, preload_en, load_in, port_in,
    input  port_out, preload_addr, preload_act_n, op_out, carry_out, halted
  );

  modport slave (
    input  loader_en, load, run, preload_en, load_in, port_in,
    output port_out, preload_addr, preload_act_n, op_out, carry_out, halted
  );
endinterface

// File: rtl/mc_gen2.sv
// Two-cycle fetch/execute accumulator microcontroller with unified program/data RAM,
// button loader, power-on preload, carry flag, single-level subroutine link and halt.
module mc_gen2 #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 6,
  parameter int unsigned NPORTS = 2
) (
  input  logic     clk_i,
  input  logic     rst,
  mc_gen2_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  typedef enum logic [4:0] {
    OP_NOT  = 5'h00, OP_SUB  = 5'h01, OP_ADD  = 5'h02, OP_OR   = 5'h03,
    OP_ST   = 5'h04, OP_BZ   = 5'h05, OP_AND  = 5'h06, OP_LD   = 5'h07,
    OP_IN   = 5'h08, OP_SUBI = 5'h09, OP_ADDI = 5'h0A, OP_ORI  = 5'h0B,
    OP_OUT  = 5'h0C, OP_BRA  = 5'h0D, OP_ANDI = 5'h0E, OP_LDI  = 5'h0F,
    OP_ADC  = 5'h10, OP_SBC  = 5'h11, OP_BCS  = 5'h12, OP_JSR  = 5'h13,
    OP_RET  = 5'h14, OP_SHL  = 5'h15, OP_SHR  = 5'h16, OP_HLT  = 5'h17
  } opcode_t;

  logic [DW-1:0] mem [DEPTH];

  state_t                    state_q, state_d;
  logic [AW-1:0]             pc_q, pc_d;
  logic [DW-1:0]             a_q, a_d;
  logic                      c_q, c_d;
  logic [AW-1:0]             lr_q, lr_d;
  logic [4:0]                op_q, op_d;
  logic [NPORTS-1:0][DW-1:0] in_buf_q, in_buf_d;
  logic [NPORTS-1:0][DW-1:0] out_q, out_d;
  logic                      halted_q, halted_d;
  logic                      preloading_q, preloading_d;
  logic                      load_d_q, load_d_d;

  logic                      mem_we;
  logic [AW-1:0]             mem_waddr;
  logic [DW-1:0]             mem_wdata;

  logic [DW-1:0]             w, d, opnd, pidx, port_sel;
  logic [AW-1:0]             addr, pc_inc, pc_rel;
  logic [DW:0]               sum, diff;
  logic                      cin, bin;

  always_comb begin
    w        = mem[pc_q];
    addr     = w[AW-1:0];
    d        = mem[addr];
    pc_inc   = pc_q + AW'(1);
    pc_rel   = pc_q + addr;
    // Bit 3 of the opcode separates the immediate forms from the memory forms.
    opnd     = op_q[3] ? w : d;
    pidx     = w % DW'(NPORTS);
    port_sel = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (pidx == DW'(k)) port_sel = in_buf_q[k];
    end
    cin  = (op_q == OP_ADC) ? c_q  : 1'b0;
    bin  = (op_q == OP_SBC) ? ~c_q : 1'b0;
    sum  = {1'b0, a_q} + {1'b0, opnd} + {{DW{1'b0}}, cin};
    diff = {1'b0, a_q} - {1'b0, opnd} - {{DW{1'b0}}, bin};
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    a_d          = a_q;
    c_d          = c_q;
    lr_d         = lr_q;
    op_d         = op_q;
    in_buf_d     = in_buf_q;
    out_d        = out_q;
    halted_d     = halted_q;
    preloading_d = preloading_q;
    load_d_d     = bus.load;
    mem_we       = 1'b0;
    mem_waddr    = pc_q;
    mem_wdata    = bus.load_in;

    if (preloading_q) begin
      mem_we = 1'b1;
      pc_d   = pc_inc;
      if (pc_q == '1) preloading_d = 1'b0;
    end else if (bus.loader_en) begin
      if (bus.load && !load_d_q) begin
        mem_we = 1'b1;
        pc_d   = pc_inc;
      end
    end else if (bus.run && !halted_q) begin
      if (state_q == S_FETCH) begin
        op_d     = w[4:0];
        in_buf_d = bus.port_in;
        pc_d     = pc_inc;
        state_d  = S_EXEC;
      end else begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op_q)
          OP_NOT:                  a_d = ~a_q;
          OP_SUB, OP_SUBI, OP_SBC: begin
            a_d = diff[DW-1:0];
            c_d = ~diff[DW];
          end
          OP_ADD, OP_ADDI, OP_ADC: begin
            a_d = sum[DW-1:0];
            c_d = sum[DW];
          end
          OP_OR,  OP_ORI:          a_d = a_q | opnd;
          OP_AND, OP_ANDI:         a_d = a_q & opnd;
          OP_LD,  OP_LDI:          a_d = opnd;
          OP_ST: begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = a_q;
          end
          OP_BZ:  if (a_q == '0) pc_d = pc_rel;
          OP_BCS: if (c_q)       pc_d = pc_rel;
          OP_BRA:                pc_d = pc_rel;
          OP_IN:                 a_d  = port_sel;
          OP_OUT: begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
              if (pidx == DW'(k)) out_d[k] = a_q;
            end
          end
          OP_JSR: begin
            lr_d = pc_inc;
            pc_d = addr;
          end
          OP_RET:                pc_d = lr_q;
          OP_SHL: begin
            c_d = a_q[DW-1];
            a_d = {a_q[DW-2:0], 1'b0};
          end
          OP_SHR: begin
            c_d = a_q[0];
            a_d = {1'b0, a_q[DW-1:1]};
          end
          OP_HLT:                halted_d = 1'b1;
          default: ;
        endcase
      end
    end

    // Dropping run releases a halt regardless of which mode owns the cycle.
    if (!bus.run) halted_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      a_q          <= '0;
      c_q          <= 1'b0;
      lr_q         <= '0;
      op_q         <= '0;
      in_buf_q     <= '0;
      out_q        <= '0;
      halted_q     <= 1'b0;
      preloading_q <= bus.preload_en;
      load_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      a_q          <= a_d;
      c_q          <= c_d;
      lr_q         <= lr_d;
      op_q         <= op_d;
      in_buf_q     <= in_buf_d;
      out_q        <= out_d;
      halted_q     <= halted_d;
      preloading_q <= preloading_d;
      load_d_q     <= load_d_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.port_out      = out_q;
  assign bus.preload_addr  = pc_q;
  assign bus.preload_act_n = ~preloading_q;
  assign bus.op_out        = op_q;
  assign bus.carry_out     = c_q;
  assign bus.halted        = halted_q;
endmodule

// File: tb/tb_mc_gen2.sv
// Self-checking bench for mc_gen2: instruction-level reference model compared every cycle,
// plus directed programs with hand-computed expectations.
module tb_mc_gen2;
  logic clk_i;
  logic rst;

  mc_gen2_if #(.DW(8), .AW(6), .NPORTS(2)) bus ();

  mc_gen2 #(.DW(8), .AW(6), .NPORTS(2)) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  // Reference machine state.
  int mmem [64];
  int m_pc, m_a, m_c, m_lr, m_op, m_mid, m_halt, m_pre, m_load_d;
  int m_inb [2];
  int m_out [2];

  logic [7:0] prog [$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_add(input int v, input int ci);
    int s;
    s   = m_a + v + ci;
    m_c = (s > 255) ? 1 : 0;
    m_a = s % 256;
  endtask

  task automatic m_sub(input int v, input int bi);
    int t;
    t   = v + bi;
    m_c = (m_a >= t) ? 1 : 0;
    m_a = (m_a - t + 512) % 256;
  endtask

  task automatic model_exec();
    int w, ad, pi, nxt;
    w   = mmem[m_pc];
    ad  = w % 64;
    pi  = w % 2;
    nxt = (m_pc + 1) % 64;
    case (m_op)
      0:  m_a = 255 - m_a;
      1:  m_sub(mmem[ad], 0);
      2:  m_add(mmem[ad], 0);
      3:  m_a = m_a | mmem[ad];
      4:  mmem[ad] = m_a;
      5:  if (m_a == 0) nxt = (m_pc + w) % 64;
      6:  m_a = m_a & mmem[ad];
      7:  m_a = mmem[ad];
      8:  m_a = m_inb[pi];
      9:  m_sub(w, 0);
      10: m_add(w, 0);
      11: m_a = m_a | w;
      12: m_out[pi] = m_a;
      13: nxt = (m_pc + w) % 64;
      14: m_a = m_a & w;
      15: m_a = w;
      16: m_add(mmem[ad], m_c);
      17: m_sub(mmem[ad], (m_c != 0) ? 0 : 1);
      18: if (m_c != 0) nxt = (m_pc + w) % 64;
      19: begin m_lr = (m_pc + 1) % 64; nxt = ad; end
      20: nxt = m_lr;
      21: begin m_c = m_a / 128; m_a = (m_a * 2) % 256; end
      22: begin m_c = m_a % 2;   m_a = m_a / 2; end
      23: m_halt = 1;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic model_step();
    int prev;
    if (rst) begin
      m_pc = 0; m_a = 0; m_c = 0; m_lr = 0; m_op = 0; m_mid = 0; m_halt = 0;
      m_pre = bus.preload_en ? 1 : 0;
      m_load_d = 0;
      m_inb[0] = 0; m_inb[1] = 0; m_out[0] = 0; m_out[1] = 0;
      started = 1;
      return;
    end
    prev     = m_load_d;
    m_load_d = bus.load ? 1 : 0;
    if (m_pre != 0) begin
      mmem[m_pc] = int'(bus.load_in);
      if (m_pc == 63) m_pre = 0;
      m_pc = (m_pc + 1) % 64;
    end else if (bus.loader_en) begin
      if (bus.load && prev == 0) begin
        mmem[m_pc] = int'(bus.load_in);
        m_pc = (m_pc + 1) % 64;
      end
    end else if (bus.run && m_halt == 0) begin
      if (m_mid == 0) begin
        m_op     = mmem[m_pc] % 32;
        m_inb[0] = int'(bus.port_in[7:0]);
        m_inb[1] = int'(bus.port_in[15:8]);
        m_pc     = (m_pc + 1) % 64;
        m_mid    = 1;
      end else begin
        model_exec();
        m_mid = 0;
      end
    end
    if (!bus.run) m_halt = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  always @(negedge clk_i) begin
    if (started) begin
      chk("port_out",      32'(bus.port_out),      m_out[1] * 256 + m_out[0]);
      chk("preload_addr",  32'(bus.preload_addr),  m_pc);
      chk("preload_act_n", 32'(bus.preload_act_n), (m_pre != 0) ? 0 : 1);
      chk("op_out",        32'(bus.op_out),        m_op);
      chk("carry_out",     32'(bus.carry_out),     m_c);
      chk("halted",        32'(bus.halted),        m_halt);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] v);
    bus.load_in = v;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
    tick();
  endtask

  task automatic load_prog();
    bus.preload_en = 1'b0;
    do_reset();
    bus.loader_en = 1'b1;
    foreach (prog[i]) load_word(prog[i]);
    bus.loader_en = 1'b0;
    do_reset();
  endtask

  task automatic run_cycles(input int n);
    bus.run = 1'b1;
    repeat (n) tick();
    bus.run = 1'b0;
  endtask

  int lowcnt;
  int r;

  initial begin
    rst            = 1'b1;
    bus.preload_en = 1'b1;
    bus.loader_en  = 1'b0;
    bus.load       = 1'b0;
    bus.run        = 1'b0;
    bus.load_in    = '0;
    bus.port_in    = '0;
    tick();
    chk("rst_port_out",     32'(bus.port_out),      0);
    chk("rst_halted",       32'(bus.halted),        0);
    chk("rst_preload_addr", 32'(bus.preload_addr),  0);
    chk("rst_preload_act",  32'(bus.preload_act_n), 0);

    // Power-on preload: load_in = address ^ 5A.
    rst = 1'b0;
    bus.preload_en = 1'b0;
    lowcnt = (bus.preload_act_n == 1'b0) ? 1 : 0;
    for (int k = 0; k < 64; k++) begin
      bus.load_in = 8'(k) ^ 8'h5A;
      tick();
      if (bus.preload_act_n == 1'b0) lowcnt++;
    end
    chk("preload_cycles",    32'(lowcnt),            64);
    chk("preload_addr_wrap", 32'(bus.preload_addr),  0);
    chk("preload_done",      32'(bus.preload_act_n), 1);

    // LD 5 / OUT 0 reads the preloaded word 05 ^ 5A.
    prog = '{8'h07, 8'h05, 8'h0C, 8'h00};
    load_prog();
    run_cycles(4);
    chk("preload_ld_out", 32'(bus.port_out[7:0]), 32'h5F);

    // LDI FF, ADDI 01, BCS +3 skips OUT 1 and lands on OUT 0.
    prog = '{8'h0F, 8'hFF, 8'h0A, 8'h01, 8'h12, 8'h03, 8'h0C, 8'h01, 8'h0C, 8'h00};
    load_prog();
    run_cycles(8);
    chk("bcs_carry", 32'(bus.carry_out),      1);
    chk("bcs_port1", 32'(bus.port_out[15:8]), 0);
    chk("bcs_pc",    32'(bus.preload_addr),   10);

    // Subtract family and shift-right.
    prog = '{8'h0F, 8'h00, 8'h04, 8'h30, 8'h0F, 8'h10, 8'h09, 8'h20, 8'h0C, 8'h00,
             8'h11, 8'h30, 8'h0C, 8'h01, 8'h16, 8'h00, 8'h0C, 8'h00, 8'h17, 8'h00};
    load_prog();
    run_cycles(10);
    chk("subi_out",   32'(bus.port_out[7:0]), 32'hF0);
    chk("subi_carry", 32'(bus.carry_out),     0);
    run_cycles(14);
    chk("sbc_out",    32'(bus.port_out[15:8]), 32'hEF);
    chk("shr_out",    32'(bus.port_out[7:0]),  32'h77);
    chk("shr_carry",  32'(bus.carry_out),      1);
    chk("hlt_flag",   32'(bus.halted),         1);
    chk("hlt_pc",     32'(bus.preload_addr),   20);

    // JSR 20 -> LDI 42, RET -> OUT 0, HLT.
    prog.delete();
    repeat (36) prog.push_back(8'h18);
    prog[0] = 8'h13; prog[1] = 8'h20; prog[2] = 8'h0C; prog[3] = 8'h00;
    prog[4] = 8'h17; prog[5] = 8'h00;
    prog[32] = 8'h0F; prog[33] = 8'h42; prog[34] = 8'h14; prog[35] = 8'h00;
    load_prog();
    run_cycles(10);
    chk("jsr_out", 32'(bus.port_out[7:0]), 32'h42);
    chk("jsr_pc",  32'(bus.preload_addr),  6);

    // A held load strobe writes once; IN 3 selects port 1.
    bus.preload_en = 1'b0;
    do_reset();
    bus.loader_en = 1'b1;
    bus.load_in   = 8'h08;
    bus.load      = 1'b1;
    repeat (5) tick();
    bus.load = 1'b0;
    tick();
    chk("loader_single", 32'(bus.preload_addr), 1);
    load_word(8'h03); load_word(8'h0C); load_word(8'h00);
    load_word(8'h17); load_word(8'h00);
    bus.loader_en = 1'b0;
    bus.port_in   = 16'hABCD;
    do_reset();
    run_cycles(6);
    chk("in_port1", 32'(bus.port_out[7:0]), 32'hAB);

    // Halt freezes despite run; one run-low cycle releases it.
    prog = '{8'h0F, 8'h33, 8'h17, 8'h00, 8'h0C, 8'h00, 8'h17, 8'h00};
    load_prog();
    run_cycles(14);
    chk("halt_pc",     32'(bus.preload_addr),  4);
    chk("halt_flag",   32'(bus.halted),        1);
    chk("halt_port0",  32'(bus.port_out[7:0]), 0);
    tick();
    chk("halt_clear",  32'(bus.halted),        0);
    run_cycles(4);
    chk("resume_out",  32'(bus.port_out[7:0]), 32'h33);

    // Random program with random run gaps, loader bursts, ports and resets.
    prog.delete();
    repeat (64) prog.push_back(8'($urandom));
    load_prog();
    for (int n = 0; n < 3000; n++) begin
      r              = int'($urandom_range(0, 999));
      rst            = (r < 3);
      bus.preload_en = 1'($urandom);
      bus.loader_en  = ($urandom_range(0, 31) == 0);
      bus.load       = 1'($urandom);
      bus.load_in    = 8'($urandom);
      bus.run        = ($urandom_range(0, 7) != 0);
      bus.port_in    = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    bus.run = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
